xorshift32_check: RTL
=====================

// Module: xorshift32_check
// PURPOSE
//  Receive-side checker for the xorshift32 stream (shifts 13/17/5, x^=x<<13; x^=x>>17; x^=x<<5).
//  Self-seeds from the incoming words, locks after a run of correct transitions, then
//  free-runs its own prediction and flags every mismatched word. Sits at the far end of
//  a link, FIFO or memory path under test and reports lock state and an error count.
// PARAMETERS
//  LOCK_COUNT   4   consecutive correct transitions required to enter LOCKED (1..255)
//  UNLOCK_ERRS  8   consecutive mismatches in LOCKED that force return to SEARCH (1..255)
//  ERRW         16  width of err_count, which saturates at all-ones
// PORTS
//  clk        in   1     single clock, all logic on posedge
//  reset      in   1     synchronous, active-high
//  valid      in   1     data carries a stream word this cycle
//  data       in   32    received stream word
//  clear      in   1     zero err_count (synchronous)
//  locked     out  1     checker is in LOCKED
//  err        out  1     one-cycle pulse: the previous valid word mismatched while LOCKED
//  err_count  out  ERRW  saturating count of mismatched words
// BEHAVIOUR
//  - step(x) is the xorshift32 transform. All outputs are registered.
//  - Reset values: locked=0, err=0, err_count=0. State=SEARCH, have_prev=0, match_cnt=0,
//    bad_run=0. Reset mid-stream aborts everything; the next valid word is a fresh seed.
//  - Cycles with valid=0 change no state except clear; err is 0 on the cycle after valid=0.
//  - SEARCH, on each valid word:
//    . data==0: have_prev<=0, match_cnt<=0. Zero is a fixed point, so it never seeds or matches.
//    . have_prev && data==step(prev): match_cnt++.
//    . otherwise: match_cnt<=0.
//    . For nonzero data: prev<=data, have_prev<=1.
//    . A match that brings match_cnt to LOCK_COUNT goes to LOCKED, sets expect<=step(data)
//      and bad_run<=0. locked rises the cycle after that word.
//    . err never pulses in SEARCH, and err_count is unchanged in SEARCH.
//  - LOCKED, on each valid word:
//    . expect<=step(expect) always. Prediction never reloads from data, so a corrupt word
//      does not corrupt later predictions.
//    . data!=expect: err=1 on the next cycle, err_count++ (saturating), bad_run++.
//    . data==expect: bad_run<=0.
//    . If the mismatch brings bad_run to UNLOCK_ERRS: that word still pulses err and counts.
//      Next state is SEARCH with locked=0 the following cycle, match_cnt<=0, and
//      prev<=data / have_prev<=(data!=0), so this word is the new seed candidate.
//  - clear: err_count<=0. Clear beats a same-cycle increment, giving a result of 0.
//  - Dropped or duplicated words in LOCKED read as a mismatch run, which leads to UNLOCK
//    and then relock. There is no slip-tolerant realignment.
// TESTING
//  1 Generator stream from seed 32'hebd5a728, valid every cycle -> locked rises the cycle
//    after word 5 (seed + 4 matches); err stays 0 over 1000 words; err_count=0.
//  2 While LOCKED, flip bit 0 of one word -> err high exactly 1 cycle, err_count=1,
//    locked stays 1, and the next uncorrupted word produces no err.
//  3 While LOCKED, feed 8 words of 32'h0 -> 8 err pulses, err_count=8, locked=0 after the
//    8th. Resuming the generator stream then relocks after 5 words.
//  4 From reset, 20 words of 32'h0, then 20 words of a constant 32'h1 -> locked never asserts.
//  5 Same as test 1 but valid=1 only every 3rd cycle with junk data on the idle cycles ->
//    identical word-level results; lock occurs on the 5th valid word.
//  6 ERRW=4: 20 mismatches while LOCKED (UNLOCK_ERRS=255) -> err_count holds 15. Assert
//    clear together with a mismatch -> err_count=0. Assert reset while LOCKED -> all
//    outputs 0 on the next cycle.

Source files
------------

// File: rtl/xorshift32_check.sv
// ---------------------------------------------------------------------------
// xorshift32_check
// Receive-side checker for an xorshift32 stream (x^=x<<13; x^=x>>17; x^=x<<5).
// Seeds itself from incoming words. After LOCK_COUNT consecutive correct
// transitions it locks and free-runs its own prediction. While locked it
// flags every word that differs from the prediction.
//
// Ports
//   clk        in   1     single clock, posedge
//   reset      in   1     synchronous, active-high
//   valid      in   1     data carries a stream word this cycle
//   data       in   32    received stream word
//   clear      in   1     zero err_count (wins over a same-cycle increment)
//   locked     out  1     checker is in LOCKED
//   err        out  1     one-cycle pulse: previous valid word mismatched while LOCKED
//   err_count  out  ERRW  saturating mismatch count
//
// state   | meaning
// SEARCH  | seeding from received words, counting correct transitions
// LOCKED  | free-running prediction, counting mismatches
// ---------------------------------------------------------------------------
module xorshift32_check #(
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 8,
  parameter int ERRW        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [31:0]     data,
  input  logic            clear,
  output logic            locked,
  output logic            err,
  output logic [ERRW-1:0] err_count
);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  function automatic logic [31:0] step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  logic [0:0]      r_state;
  logic [31:0]     r_prev;
  logic            r_have_prev;
  logic [7:0]      r_match_cnt;
  logic [31:0]     r_expect;
  logic [7:0]      r_bad_run;
  logic            r_err;
  logic [ERRW-1:0] r_err_count;

  logic [31:0] w_step_prev;
  logic [31:0] w_step_data;
  logic [31:0] w_step_expect;
  logic [7:0]  w_match_next;
  logic [7:0]  w_bad_next;

  assign w_step_prev   = step(r_prev);
  assign w_step_data   = step(data);
  assign w_step_expect = step(r_expect);
  assign w_match_next  = r_match_cnt + 8'd1;
  assign w_bad_next    = r_bad_run + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_SEARCH;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_match_cnt <= '0;
      r_expect    <= '0;
      r_bad_run   <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err <= 1'b0;
      if (valid) begin
        if (r_state == ST_SEARCH) begin
          // Zero is a fixed point of the transform: it can neither seed nor match.
          if (data == 32'd0) begin
            r_have_prev <= 1'b0;
            r_match_cnt <= '0;
          end else begin
            r_prev      <= data;
            r_have_prev <= 1'b1;
            if (r_have_prev && (data == w_step_prev)) begin
              if (w_match_next == 8'(LOCK_COUNT)) begin
                r_state     <= ST_LOCKED;
                r_expect    <= w_step_data;
                r_bad_run   <= '0;
                r_match_cnt <= '0;
              end else begin
                r_match_cnt <= w_match_next;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
        end else begin
          // Prediction advances on its own so a corrupt word cannot poison it.
          r_expect <= w_step_expect;
          if (data != r_expect) begin
            r_err <= 1'b1;
            if (r_err_count != '1) r_err_count <= r_err_count + ERRW'(1);
            if (w_bad_next == 8'(UNLOCK_ERRS)) begin
              // The word that forces unlock becomes the next seed candidate.
              r_state     <= ST_SEARCH;
              r_match_cnt <= '0;
              r_prev      <= data;
              r_have_prev <= (data != 32'd0);
              r_bad_run   <= '0;
            end else begin
              r_bad_run <= w_bad_next;
            end
          end else begin
            r_bad_run <= '0;
          end
        end
      end
      if (clear) r_err_count <= '0;
    end
  end

  assign locked    = r_state;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule
